// File: rtl/apb_pkg.sv
// Shared APB manager types: FSM state encoding, the registered response record
// and fixed APB field widths.
package apb_pkg;

    localparam int PROT_WIDTH     = 4;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rData;
        logic                      error;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state watchdog for the APB ACCESS phase: reloads on clear, counts down
// while enabled and flags expiry on its last permitted cycle.
module apb_wait_timer #(
    parameter int TimeoutCycles = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (TimeoutCycles == 0) begin : g_disabled
        assign expired = 1'b0;
    end else begin : g_count
        localparam int                CntWidth = $clog2(TimeoutCycles + 1);
        localparam logic [CntWidth-1:0] Load   = CntWidth'(TimeoutCycles - 1);

        // Cycles left before an un-ready ACCESS cycle is treated as a hang.
        logic [CntWidth-1:0] remaining;

        always_ff @(posedge clk) begin
            if (reset) begin
                remaining <= '0;
            end else if (clear) begin
                remaining <= Load;
            end else if (enable && remaining != '0) begin
                remaining <= remaining - 1'b1;
            end
        end

        assign expired = (remaining == '0);
    end

endmodule

// File: rtl/apb_manager.sv
// Single-manager APB requester: turns a valid/ready command stream into
// SETUP/ACCESS transfers and returns one response per command.
module apb_manager
    import apb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = APB_DATA_WIDTH,
    parameter int TimeoutCycles = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic                   cmdWrite,
    input  logic [AddrWidth-1:0]   cmdAddr,
    input  logic [DataWidth-1:0]   cmdWData,
    input  logic [DataWidth/8-1:0] cmdStrb,
    input  logic [PROT_WIDTH-1:0]  cmdProt,

    output logic                   rspValid,
    input  logic                   rspReady,
    output logic [DataWidth-1:0]   rspRData,
    output logic                   rspError,

    output logic [AddrWidth-1:0]   addr,
    output logic [PROT_WIDTH-1:0]  prot,
    output logic                   selector_0,
    output logic                   enable,
    output logic                   write,
    output logic [DataWidth-1:0]   wData,
    output logic [DataWidth/8-1:0] strb,

    input  logic                   ready,
    input  logic [DataWidth-1:0]   rData,
    input  logic                   slvError
);

    apb_state_e state_q, state_d;
    apb_rsp_t   rsp_q, rsp_d;
    logic       accept;
    logic       timer_expired;

    apb_wait_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == SETUP),
        .enable (state_q == ACCESS && !ready),
        .expired(timer_expired)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        rsp_d   = rsp_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (ready) begin
                    state_d     = RESP;
                    rsp_d.rData = write ? '0 : APB_DATA_WIDTH'(rData);
                    rsp_d.error = slvError;
                end else if (timer_expired) begin
                    state_d     = RESP;
                    rsp_d.rData = '0;
                    rsp_d.error = 1'b1;
                end
            end
            RESP: begin
                if (rspReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, and reset
        // is sampled on the clock edge like any other input.
        if (reset) begin
            state_q    <= IDLE;
            rsp_q      <= '0;
            addr       <= '0;
            prot       <= '0;
            write      <= 1'b0;
            wData      <= '0;
            strb       <= '0;
            selector_0 <= 1'b0;
            enable     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_q      <= rsp_d;
            // Phase strobes follow the next state so they are glitch-free flops.
            selector_0 <= (state_d == SETUP) || (state_d == ACCESS);
            enable     <= (state_d == ACCESS);
            if (accept) begin
                addr  <= cmdAddr;
                prot  <= cmdProt;
                write <= cmdWrite;
                wData <= cmdWrite ? cmdWData : '0;
                strb  <= cmdWrite ? cmdStrb  : '0;
            end
        end
    end

    assign cmdReady = (state_q == IDLE);
    assign rspValid = (state_q == RESP);
    assign rspRData = DataWidth'(rsp_q.rData);
    assign rspError = rsp_q.error;

endmodule

// File: tb/tb_apb_manager.sv
// Self-checking bench for apb_manager: directed vector table, mid-transfer
// reset sequence, then randomized commands against a closed-form reference.
module tb_apb_manager;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic          cmdWrite = 1'b0;
    logic [AW-1:0] cmdAddr = '0;
    logic [DW-1:0] cmdWData = '0;
    logic [SW-1:0] cmdStrb = '0;
    logic [3:0]    cmdProt = '0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [DW-1:0] rspRData;
    logic          rspError;
    logic [AW-1:0] addr;
    logic [3:0]    prot;
    logic          selector_0;
    logic          enable;
    logic          write;
    logic [DW-1:0] wData;
    logic [SW-1:0] strb;
    logic          ready = 1'b0;
    logic [DW-1:0] rData = '0;
    logic          slvError = 1'b0;

    always #5 clk = ~clk;

    apb_manager #(
        .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdWData(cmdWData), .cmdStrb(cmdStrb), .cmdProt(cmdProt),
        .rspValid(rspValid), .rspReady(rspReady), .rspRData(rspRData), .rspError(rspError),
        .addr(addr), .prot(prot), .selector_0(selector_0), .enable(enable),
        .write(write), .wData(wData), .strb(strb),
        .ready(ready), .rData(rData), .slvError(slvError)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_prot"}, prot, 0);
        check({tag, "_sel"}, selector_0, 0);
        check({tag, "_en"}, enable, 0);
        check({tag, "_write"}, write, 0);
        check({tag, "_wdata"}, wData, 0);
        check({tag, "_strb"}, strb, 0);
        check({tag, "_rspvalid"}, rspValid, 0);
        check({tag, "_rsprdata"}, rspRData, 0);
        check({tag, "_rsperror"}, rspError, 0);
        check({tag, "_cmdready"}, cmdReady, 1);
    endtask

    // Issue one command, play the peripheral with `waits` un-ready ACCESS cycles,
    // hold the response for `bp` cycles, and compare against the expectation.
    task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [3:0] p, input int waits,
                           input logic [DW-1:0] rd, input logic se, input int bp,
                           input logic [DW-1:0] exp_d, input logic exp_e, input int exp_acc);
        int n_access;
        int guard;
        check("idle_cmdready", cmdReady, 1);
        cmdValid = 1'b1; cmdWrite = w; cmdAddr = a; cmdWData = d; cmdStrb = s; cmdProt = p;
        ready = 1'b1; slvError = 1'b1; rData = $urandom;
        tick();
        cmdValid = 1'b0; cmdAddr = $urandom; cmdWData = $urandom; cmdStrb = 4'($urandom);
        check("setup_sel", selector_0, 1);
        check("setup_en", enable, 0);
        check("setup_addr", addr, a);
        check("setup_prot", prot, p);
        check("setup_write", write, w);
        check("setup_wdata", wData, w ? d : '0);
        check("setup_strb", strb, w ? s : '0);
        check("setup_cmdready", cmdReady, 0);
        check("setup_rspvalid", rspValid, 0);
        tick();
        n_access = 0;
        guard = 0;
        while (enable === 1'b1 && guard < 100) begin
            n_access++;
            guard++;
            check("access_sel", selector_0, 1);
            check("access_addr", addr, a);
            ready    = (n_access > waits);
            rData    = (n_access > waits) ? rd : $urandom;
            slvError = (n_access > waits) ? se : 1'($urandom);
            tick();
        end
        check("access_cycles", n_access, exp_acc);
        ready = 1'b1; slvError = 1'b1; rData = $urandom;
        check("rsp_valid", rspValid, 1);
        check("rsp_sel", selector_0, 0);
        check("rsp_en", enable, 0);
        check("rsp_rdata", rspRData, exp_d);
        check("rsp_error", rspError, exp_e);
        check("rsp_addr_hold", addr, a);
        check("rsp_cmdready", cmdReady, 0);
        rspReady = 1'b0;
        repeat (bp) begin
            tick();
            check("bp_valid", rspValid, 1);
            check("bp_rdata", rspRData, exp_d);
            check("bp_error", rspError, exp_e);
            check("bp_cmdready", cmdReady, 0);
        end
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0; ready = 1'b0; slvError = 1'b0;
        check("done_rspvalid", rspValid, 0);
        check("done_cmdready", cmdReady, 1);
    endtask

    // Response rules stated as plain arithmetic on the wait count.
    function automatic void ref_model(input logic w, input int waits, input logic [DW-1:0] rd,
                                      input logic se, output logic [DW-1:0] d, output logic e,
                                      output int acc);
        if (TO != 0 && waits >= TO) begin
            d = '0; e = 1'b1; acc = TO;
        end else begin
            d = w ? '0 : rd; e = se; acc = waits + 1;
        end
    endfunction

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [3:0]    p;
        int            waits;
        logic [DW-1:0] rd;
        logic          se;
        int            bp;
        logic [DW-1:0] exp_d;
        logic          exp_e;
        int            exp_acc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'h0,  0, 32'hAAAA5555, 1'b0,  0, 32'h0,        1'b0,  1};
        vecs[1] = '{1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 4'h2,  3, 32'h12345678, 1'b0,  1, 32'h12345678, 1'b0,  4};
        vecs[2] = '{1'b0, 32'h24, 32'h5A5A5A5A, 4'hC, 4'h1,  1, 32'hCAFEF00D, 1'b1,  0, 32'hCAFEF00D, 1'b1,  2};
        vecs[3] = '{1'b0, 32'h30, 32'h0,        4'h0, 4'h0, 40, 32'h11111111, 1'b0,  0, 32'h0,        1'b1, 16};
        vecs[4] = '{1'b1, 32'h34, 32'h01020304, 4'h5, 4'h4,  2, 32'h99999999, 1'b0,  2, 32'h0,        1'b0,  3};
        vecs[5] = '{1'b0, 32'h38, 32'h0,        4'h0, 4'h6, 15, 32'h0BADBEEF, 1'b0,  0, 32'h0BADBEEF, 1'b0, 16};
        vecs[6] = '{1'b1, 32'h3C, 32'h76543210, 4'h3, 4'h7, 16, 32'h22222222, 1'b0,  0, 32'h0,        1'b1, 16};
        vecs[7] = '{1'b1, 32'h44, 32'h0F0F0F0F, 4'h9, 4'h5,  0, 32'h33333333, 1'b1, 10, 32'h0,        1'b1,  1};

        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].p, vecs[i].waits,
                    vecs[i].rd, vecs[i].se, vecs[i].bp, vecs[i].exp_d, vecs[i].exp_e,
                    vecs[i].exp_acc);
        end

        // Reset landing in ACCESS drops the transfer without a response.
        cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 32'h40; cmdProt = 4'h3; ready = 1'b0;
        tick();
        cmdValid = 1'b0;
        tick();
        check("mid_access_en", enable, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midrst");
        ready = 1'b1; slvError = 1'b1;
        repeat (3) begin
            tick();
            check("midrst_norsp", rspValid, 0);
            check("midrst_nosel", selector_0, 0);
        end
        ready = 1'b0; slvError = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic          w, se;
            logic [AW-1:0] a;
            logic [DW-1:0] d, rd, exp_d;
            logic [SW-1:0] s;
            logic [3:0]    p;
            logic          exp_e;
            int            waits, bp, exp_acc;
            w = 1'($urandom); se = 1'($urandom);
            a = $urandom; d = $urandom; rd = $urandom;
            s = 4'($urandom); p = 4'($urandom);
            waits = $urandom_range(0, 20);
            bp = $urandom_range(0, 3);
            ref_model(w, waits, rd, se, exp_d, exp_e, exp_acc);
            run_cmd(w, a, d, s, p, waits, rd, se, bp, exp_d, exp_e, exp_acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
